// File: rtl/gmii_pkg.sv
// Shared GMII receive definitions: framing bytes, parser states, default frame geometry.
package gmii_pkg;

  localparam logic [7:0] GMII_PREAMBLE = 8'h55;
  localparam logic [7:0] GMII_SFD      = 8'hd5;

  localparam int unsigned DEF_PRE_MIN = 7;
  localparam int unsigned DEF_HDR_LEN = 12;
  localparam int unsigned DEF_FCS_LEN = 4;
  localparam int unsigned DEF_CNT_W   = 32;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PRE,
    ST_HDR,
    ST_PAYLOAD,
    ST_DROP
  } state_t;

  // One stage of the FCS-strip delay line.
  typedef struct packed {
    logic [7:0] data;
    logic       tag;
  } tap_t;

endpackage

// File: rtl/gmii_tail_strip.sv
// Tagged delay line that holds back the last DEPTH bytes of a frame so the FCS never leaves.
module gmii_tail_strip
  import gmii_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_FCS_LEN
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [7:0] data,
  input  logic       dv,
  input  logic       push,
  output logic [7:0] tx_data,
  output logic       tx_data_en,
  output logic       emit_c
);

  tap_t line [DEPTH];

  // A byte reaching the oldest stage while a new byte arrives has DEPTH newer bytes behind it.
  assign emit_c = push && line[DEPTH-1].tag;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_data    <= 8'h00;
      tx_data_en <= 1'b0;
      for (int i = 0; i < int'(DEPTH); i++) line[i] <= '0;
    end else begin
      tx_data_en <= emit_c;
      if (emit_c) tx_data <= line[DEPTH-1].data;
      // dv fall: whatever is still held is FCS, drop it.
      if (!dv) begin
        for (int i = 0; i < int'(DEPTH); i++) line[i] <= '0;
      end else if (push) begin
        line[0] <= '{data: data, tag: 1'b1};
        for (int i = 1; i < int'(DEPTH); i++) line[i] <= line[i-1];
      end
    end
  end

endmodule

// File: rtl/gmii_payload_extract.sv
// GMII receive parser: validates preamble/SFD, skips DA+SA, strips FCS and streams payload bytes.
module gmii_payload_extract
  import gmii_pkg::*;
#(
  parameter int unsigned PRE_MIN = DEF_PRE_MIN,
  parameter int unsigned HDR_LEN = DEF_HDR_LEN,
  parameter int unsigned FCS_LEN = DEF_FCS_LEN,
  parameter int unsigned CNT_W   = DEF_CNT_W
) (
  input  logic             I_sys_clk,
  input  logic             I_sys_rst_n,
  input  logic [7:0]       I_gmii_data,
  input  logic             I_gmii_dv,
  output logic [7:0]       O_tx_data,
  output logic             O_tx_data_en,
  output logic             O_pkt_start,
  output logic             O_pkt_end,
  output logic             O_frame_err,
  output logic [CNT_W-1:0] O_frame_cnt
);

  localparam int unsigned HCNT_W = $clog2(HDR_LEN + 1);
  localparam int unsigned BCNT_W = $clog2(FCS_LEN + 2);

  state_t            state;
  logic [3:0]        pcnt;
  logic [HCNT_W-1:0] hcnt;
  logic [BCNT_W-1:0] bcnt;
  logic              started;
  logic              push_c;
  logic              emit_c;

  assign push_c = I_gmii_dv && (state == ST_PAYLOAD);

  gmii_tail_strip #(
    .DEPTH(FCS_LEN)
  ) u_tail (
    .clk       (I_sys_clk),
    .rst_n     (I_sys_rst_n),
    .data      (I_gmii_data),
    .dv        (I_gmii_dv),
    .push      (push_c),
    .tx_data   (O_tx_data),
    .tx_data_en(O_tx_data_en),
    .emit_c    (emit_c)
  );

  always_ff @(posedge I_sys_clk or negedge I_sys_rst_n) begin
    if (!I_sys_rst_n) begin
      state       <= ST_IDLE;
      pcnt        <= 4'd0;
      hcnt        <= '0;
      bcnt        <= '0;
      started     <= 1'b0;
      O_pkt_start <= 1'b0;
      O_pkt_end   <= 1'b0;
      O_frame_err <= 1'b0;
      O_frame_cnt <= '0;
    end else begin
      O_pkt_end   <= 1'b0;
      O_frame_err <= 1'b0;
      O_pkt_start <= emit_c && !started;
      if (emit_c) started <= 1'b1;

      case (state)
        ST_IDLE: begin
          started <= 1'b0;
          if (I_gmii_dv) begin
            if (I_gmii_data == GMII_PREAMBLE) begin
              state <= ST_PRE;
              pcnt  <= 4'd1;
            end else begin
              state <= ST_DROP;
            end
          end
        end
        ST_PRE: begin
          if (!I_gmii_dv) begin
            state <= ST_IDLE;
          end else if (I_gmii_data == GMII_PREAMBLE) begin
            if (pcnt != 4'd15) pcnt <= pcnt + 4'd1;
          end else if (I_gmii_data == GMII_SFD && pcnt >= 4'(PRE_MIN)) begin
            state <= ST_HDR;
            hcnt  <= '0;
          end else begin
            state <= ST_DROP;
          end
        end
        ST_HDR: begin
          if (!I_gmii_dv) begin
            state       <= ST_IDLE;
            O_pkt_end   <= 1'b1;
            O_frame_err <= 1'b1;
          end else if (hcnt == HCNT_W'(HDR_LEN - 1)) begin
            state <= ST_PAYLOAD;
            bcnt  <= '0;
          end else begin
            hcnt <= hcnt + HCNT_W'(1);
          end
        end
        ST_PAYLOAD: begin
          // bcnt saturates once the body is long enough to carry at least one payload byte.
          if (!I_gmii_dv) begin
            state     <= ST_IDLE;
            O_pkt_end <= 1'b1;
            if (bcnt > BCNT_W'(FCS_LEN)) O_frame_cnt <= O_frame_cnt + CNT_W'(1);
            else                         O_frame_err <= 1'b1;
          end else if (bcnt <= BCNT_W'(FCS_LEN)) begin
            bcnt <= bcnt + BCNT_W'(1);
          end
        end
        ST_DROP: begin
          if (!I_gmii_dv) begin
            state       <= ST_IDLE;
            O_pkt_end   <= 1'b1;
            O_frame_err <= 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gmii_payload_extract.sv
// Scoreboard bench: a byte-list frame model predicts payload bytes, pulses and counts per frame.
module tb_gmii_payload_extract;

  typedef logic [7:0] bq_t[$];

  typedef struct packed {
    logic [7:0] d;
    logic       first;
    int         due;
  } exp_byte_t;

  typedef struct packed {
    logic        err;
    logic [31:0] cnt;
    int          due;
  } exp_end_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  gdata;
  logic        gdv;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        pkt_start;
  logic        pkt_end;
  logic        frame_err;
  logic [31:0] frame_cnt;

  int          cyc = 0;
  int          tests = 0;
  int          fails = 0;
  int          good_cnt = 0;
  exp_byte_t   exp_data[$];
  exp_end_t    exp_end[$];

  gmii_payload_extract dut (
    .I_sys_clk   (clk),
    .I_sys_rst_n (rst_n),
    .I_gmii_data (gdata),
    .I_gmii_dv   (gdv),
    .O_tx_data   (tx_data),
    .O_tx_data_en(tx_en),
    .O_pkt_start (pkt_start),
    .O_pkt_end   (pkt_end),
    .O_frame_err (frame_err),
    .O_frame_cnt (frame_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic flag_unexpected(input string name);
    tests++;
    fails++;
    $display("FAIL %s: output with no pending expectation (cycle %0d)", name, cyc);
  endtask

  // Frame-level rules: preamble >= 7 then SFD, 12 header bytes, last 4 bytes are FCS.
  task automatic model(input bq_t q, input int c0);
    int n;
    int p;
    int r;
    bit pulse;
    bit bad;
    n = q.size();
    p = 0;
    pulse = 1'b1;
    bad = 1'b1;
    if (n == 0) return;
    while (p < n && q[p] == 8'h55) p++;
    if (p == n) begin
      pulse = 1'b0;
    end else if (p >= 7 && q[p] == 8'hd5) begin
      r = n - p - 1;
      if (r - 12 >= 5) begin
        bad = 1'b0;
        for (int j = p + 13; j <= n - 5; j++)
          exp_data.push_back('{d: q[j], first: (j == p + 13), due: c0 + j + 5});
      end
    end
    if (pulse) begin
      if (!bad) good_cnt++;
      exp_end.push_back('{err: bad, cnt: 32'(good_cnt), due: c0 + n + 1});
    end
  endtask

  // Drive one frame with dv high throughout, then idle cycles; rst_at >= 0 resets mid-frame.
  task automatic send_frame(input bq_t q, input int idle, input int rst_at);
    int c0;
    @(posedge clk);
    #1;
    c0 = cyc;
    model(q, c0);
    for (int k = 0; k < q.size(); k++) begin
      if (k > 0) begin
        @(posedge clk);
        #1;
      end
      gdata = q[k];
      gdv   = 1'b1;
      if (k == rst_at) begin
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_tx_data", 64'(tx_data), 64'h0);
        chk("rst_tx_en", 64'(tx_en), 64'h0);
        chk("rst_pkt_start", 64'(pkt_start), 64'h0);
        chk("rst_pkt_end", 64'(pkt_end), 64'h0);
        chk("rst_frame_err", 64'(frame_err), 64'h0);
        chk("rst_frame_cnt", 64'(frame_cnt), 64'h0);
        exp_data.delete();
        exp_end.delete();
        good_cnt = 0;
        gdv = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);
        return;
      end
    end
    @(posedge clk);
    #1;
    gdv   = 1'b0;
    gdata = 8'($urandom);
    repeat (idle - 1) @(posedge clk);
  endtask

  function automatic bq_t build(input int pre, input int hdr, input bq_t body);
    bq_t q;
    for (int i = 0; i < pre; i++) q.push_back(8'h55);
    q.push_back(8'hd5);
    for (int i = 0; i < hdr; i++) q.push_back(i < 6 ? 8'hda : 8'h5a);
    foreach (body[i]) q.push_back(body[i]);
    return q;
  endfunction

  function automatic bq_t frame1();
    bq_t b;
    b = '{8'h0a, 8'h0b, 8'h0a, 8'h0b, 8'h0c, 8'h0b, 8'h0a, 8'h0b};
    repeat (12) b.push_back(8'h0c);
    repeat (4) b.push_back(8'h04);
    return build(7, 12, b);
  endfunction

  function automatic bq_t rand_body(input int len);
    bq_t b;
    for (int i = 0; i < len; i++) b.push_back(8'($urandom));
    return b;
  endfunction

  // Monitor: every DUT presentation is matched against the head of a queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (tx_en) begin
        if (exp_data.size() == 0) flag_unexpected("tx_data_en");
        else begin
          exp_byte_t e;
          e = exp_data.pop_front();
          chk("tx_data", 64'(tx_data), 64'(e.d));
          chk("tx_cycle", 64'(cyc), 64'(e.due));
          chk("pkt_start", 64'(pkt_start), 64'(e.first));
        end
      end else if (pkt_start) begin
        flag_unexpected("pkt_start_without_data");
      end
      if (pkt_end) begin
        if (exp_end.size() == 0) flag_unexpected("pkt_end");
        else begin
          exp_end_t e;
          e = exp_end.pop_front();
          chk("frame_err", 64'(frame_err), 64'(e.err));
          chk("frame_cnt", 64'(frame_cnt), 64'(e.cnt));
          chk("pkt_end_cycle", 64'(cyc), 64'(e.due));
        end
      end else if (frame_err) begin
        flag_unexpected("frame_err_without_end");
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    bq_t q;
    int  kind;
    rst_n = 1'b0;
    gdv   = 1'b0;
    gdata = 8'h00;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_tx_en", 64'(tx_en), 64'h0);
    chk("reset_tx_data", 64'(tx_data), 64'h0);
    chk("reset_pkt_end", 64'(pkt_end), 64'h0);
    chk("reset_frame_cnt", 64'(frame_cnt), 64'h0);
    rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // Reference frame, then twenty copies.
    send_frame(frame1(), 8, -1);
    for (int i = 0; i < 20; i++) send_frame(frame1(), 8, -1);

    // Short preamble, header abort, marginal bodies.
    send_frame(build(6, 12, rand_body(20)), 3, -1);
    send_frame(build(7, 3, rand_body(0)), 1, -1);
    send_frame(frame1(), 2, -1);
    send_frame(build(7, 12, rand_body(4)), 1, -1);
    send_frame(build(7, 12, rand_body(5)), 1, -1);
    send_frame(build(7, 12, rand_body(0)), 1, -1);

    // Randomized frames with mixed defects and minimum gaps.
    for (int i = 0; i < 40; i++) begin
      kind = int'($urandom_range(0, 9));
      q.delete();
      case (kind)
        0: begin
          q = rand_body(int'($urandom_range(1, 10)));
          q[0] = 8'h11;
        end
        1: q = build(int'($urandom_range(1, 6)), 12, rand_body(10));
        2: for (int j = 0; j < int'($urandom_range(1, 9)); j++) q.push_back(8'h55);
        3: begin
          q = build(int'($urandom_range(7, 18)), 12, rand_body(10));
          q[q.size() - 23] = 8'h33;
        end
        default: q = build(int'($urandom_range(7, 18)), 12,
                           rand_body(int'($urandom_range(0, 30))));
      endcase
      send_frame(q, int'($urandom_range(1, 5)), -1);
    end

    // Reset in the middle of the payload, then the count restarts.
    send_frame(frame1(), 4, 30);
    send_frame(frame1(), 4, -1);
    send_frame(frame1(), 8, -1);

    repeat (20) @(posedge clk);
    #1;
    chk("final_frame_cnt", 64'(frame_cnt), 64'(good_cnt));
    chk("pending_data", 64'(exp_data.size()), 64'h0);
    chk("pending_end", 64'(exp_end.size()), 64'h0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
